// File: rtl/cyq_cnt_pkg.sv
// Shared constants and helpers for the cyq counter family (up and down variants).
package cyq_cnt_pkg;

  localparam int   CYQ_CNT_W = 4;
  localparam logic LOAD_ACT  = 1'b0;

  // Widths above 16 are outside the family's legal range and are not handled.
  function automatic logic [15:0] all_ones(input int width);
    return 16'((32'd1 << width) - 32'd1);
  endfunction

endpackage

// File: rtl/cyq_down_counter_161r_if.sv
// Control/data bundle of the cyq down-counter; clk and MR stay plain ports on the counter.
interface cyq_down_counter_161r_if #(
  parameter int WIDTH = cyq_cnt_pkg::CYQ_CNT_W
);
  logic             Cep;
  logic             Cet;
  logic             PE;
  logic [WIDTH-1:0] D;
  logic [WIDTH-1:0] Q;
  logic             TC;
  logic             WRAP;

  modport master (output Cep, Cet, PE, D, input Q, TC, WRAP);
  modport slave  (input Cep, Cet, PE, D, output Q, TC, WRAP);
endinterface

// File: rtl/cyq_down_counter_161r.sv
// Presettable synchronous down-counter with cascadable borrow TC and a registered WRAP pulse.
// Build option CYQ_DOWN_COUNTER_RELOAD_EN: underflow reloads the last loaded value instead of all-ones.
module cyq_down_counter_161r
  import cyq_cnt_pkg::*;
#(
  parameter int WIDTH = CYQ_CNT_W
) (
  input logic                    clk,
  input logic                    MR,
  cyq_down_counter_161r_if.slave bus
);

  logic [WIDTH-1:0] q_q, q_d;
  logic             wrap_q, wrap_d;
  logic [WIDTH-1:0] underflow_val;

`ifdef CYQ_DOWN_COUNTER_RELOAD_EN
  logic [WIDTH-1:0] rl_q, rl_d;
  assign underflow_val = rl_q;
`else
  assign underflow_val = WIDTH'(all_ones(WIDTH));
`endif

  always_comb begin
    q_d    = q_q;
    wrap_d = 1'b0;
`ifdef CYQ_DOWN_COUNTER_RELOAD_EN
    rl_d   = rl_q;
`endif
    // Load is deliberately not gated by either enable.
    if (bus.PE == LOAD_ACT) begin
      q_d = bus.D;
`ifdef CYQ_DOWN_COUNTER_RELOAD_EN
      rl_d = bus.D;
`endif
    end else if (bus.Cep && bus.Cet) begin
      if (q_q == '0) begin
        q_d    = underflow_val;
        wrap_d = 1'b1;
      end else begin
        q_d = q_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (MR) begin
      q_q    <= '0;
      wrap_q <= 1'b0;
`ifdef CYQ_DOWN_COUNTER_RELOAD_EN
      rl_q   <= '0;
`endif
    end else begin
      q_q    <= q_d;
      wrap_q <= wrap_d;
`ifdef CYQ_DOWN_COUNTER_RELOAD_EN
      rl_q   <= rl_d;
`endif
    end
  end

  // TC ignores Cep so a stalled lower stage still presents its borrow upstream.
  assign bus.TC   = bus.Cet & ~(|q_q);
  assign bus.Q    = q_q;
  assign bus.WRAP = wrap_q;

endmodule

// File: tb/tb_cyq_down_counter_161r.sv
// Directed plus random checks of cyq_down_counter_161r against a behavioural counting model.
module tb_cyq_down_counter_161r;

  localparam int W    = 4;
  localparam int MAXV = (1 << W) - 1;

  logic clk = 1'b0;
  logic MR  = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  cyq_down_counter_161r_if #(.WIDTH(W)) u_if ();
  cyq_down_counter_161r_if #(.WIDTH(W)) lo_if ();
  cyq_down_counter_161r_if #(.WIDTH(W)) hi_if ();

  cyq_down_counter_161r #(.WIDTH(W)) u_dut (.clk(clk), .MR(MR), .bus(u_if.slave));
  cyq_down_counter_161r #(.WIDTH(W)) u_lo  (.clk(clk), .MR(MR), .bus(lo_if.slave));
  cyq_down_counter_161r #(.WIDTH(W)) u_hi  (.clk(clk), .MR(MR), .bus(hi_if.slave));

  assign hi_if.Cep = 1'b1;
  assign hi_if.Cet = lo_if.TC;

  // Reference model state: plain integers
  int m_q = 0, m_wrap = 0, m_rl = 0;

  function automatic int after_count(input int q, input int rl);
`ifdef CYQ_DOWN_COUNTER_RELOAD_EN
    return (q == 0) ? rl : q - 1;
`else
    return (q + MAXV) % (MAXV + 1);
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic mr, input logic pe, input logic cep, input logic cet,
                      input logic [W-1:0] d, input string tag);
    MR      = mr;
    u_if.PE = pe;  u_if.Cep = cep;  u_if.Cet = cet;  u_if.D = d;
    @(posedge clk);
    if (mr) begin
      m_q = 0; m_wrap = 0; m_rl = 0;
    end else if (!pe) begin
      m_q = int'(d); m_rl = int'(d); m_wrap = 0;
    end else if (cep && cet) begin
      m_wrap = (m_q == 0) ? 1 : 0;
      m_q    = after_count(m_q, m_rl);
    end else begin
      m_wrap = 0;
    end
    #1;
    check({tag, ".Q"},    32'(u_if.Q),    32'(m_q));
    check({tag, ".WRAP"}, 32'(u_if.WRAP), 32'(m_wrap));
    check({tag, ".TC"},   32'(u_if.TC),   32'((cet && m_q == 0) ? 1 : 0));
  endtask

  initial begin
    int exp_lo, exp_hi, exp_lw, exp_hw;
    u_if.PE = 1'b1;  u_if.Cep = 1'b0;  u_if.Cet = 1'b1;  u_if.D = '0;
    lo_if.PE = 1'b1; lo_if.Cep = 1'b0; lo_if.Cet = 1'b0; lo_if.D = '0;
    hi_if.PE = 1'b1; hi_if.D = '0;

    // Reset
    step(1, 1, 0, 1, 4'h0, "rst0");
    step(1, 0, 1, 1, 4'h7, "rst1");
    check("rst_Q_const",  32'(u_if.Q),    32'h0);
    check("rst_TC_const", 32'(u_if.TC),   32'h1);
    u_if.Cet = 1'b0;
    #1;
    check("tc_follows_cet", 32'(u_if.TC), 32'h0);

    // Load 3 then count four times
    step(0, 0, 0, 0, 4'h3, "load3");
    check("load3_const", 32'(u_if.Q), 32'h3);
    for (int i = 0; i < 4; i++) step(0, 1, 1, 1, 4'h0, $sformatf("cnt%0d", i));
`ifndef CYQ_DOWN_COUNTER_RELOAD_EN
    check("underflow_allones", 32'(u_if.Q),    32'hF);
    check("underflow_wrap",    32'(u_if.WRAP), 32'h1);
`endif

    // Enables
    step(0, 0, 0, 0, 4'h5, "load5");
    step(0, 1, 0, 1, 4'h0, "hold_cep0");
    step(0, 1, 1, 0, 4'h0, "hold_cet0");
    check("hold_const", 32'(u_if.Q), 32'h5);
    step(0, 0, 0, 0, 4'h9, "load9_noen");
    check("load9_const", 32'(u_if.Q), 32'h9);

    // Simultaneous events at Q==0
    step(0, 0, 0, 0, 4'h0, "load0");
    step(0, 0, 1, 1, 4'h6, "load_beats_wrap");
    check("load_beats_wrap_const", 32'(u_if.Q), 32'h6);
    step(0, 0, 0, 0, 4'h0, "load0b");
    step(1, 0, 1, 1, 4'h6, "rst_beats_load");

    // Reset clears a pending WRAP; afterwards count from 0
    step(0, 0, 0, 0, 4'h2, "load2");
    for (int i = 0; i < 4; i++) step(0, 1, 1, 1, 4'h0, $sformatf("run2_%0d", i));
    step(0, 0, 0, 0, 4'h0, "load0c");
    step(0, 1, 1, 1, 4'h0, "wrap_pend");
    step(1, 1, 1, 1, 4'h0, "rst_midcount");
    for (int i = 0; i < 3; i++) step(0, 1, 1, 1, 4'h0, $sformatf("post_rst%0d", i));

    // Random stimulus
    for (int i = 0; i < 300; i++) begin
      step(($urandom_range(0, 29) == 0), ($urandom_range(0, 5) != 0),
           ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0),
           4'($urandom_range(0, MAXV)), $sformatf("rnd%0d", i));
    end

    // Cascade: lower stage LSBs, upper stage counts on lower TC
    u_if.PE = 1'b1; u_if.Cep = 1'b0;
    MR = 1'b0;
    for (int t = 0; t < 2; t++) begin
      logic [7:0] v;
      v = (t == 0) ? 8'h10 : 8'h00;
      lo_if.PE = 1'b0; hi_if.PE = 1'b0; lo_if.D = v[3:0]; hi_if.D = v[7:4];
      lo_if.Cep = 1'b0; lo_if.Cet = 1'b0;
      @(posedge clk); #1;
      check($sformatf("casc_load%0d", t), 32'({hi_if.Q, lo_if.Q}), 32'(v));
      lo_if.PE = 1'b1; hi_if.PE = 1'b1; lo_if.Cep = 1'b1; lo_if.Cet = 1'b1;
      exp_lw = (v[3:0] == 0) ? 1 : 0;
      exp_hw = (v[3:0] == 0 && v[7:4] == 0) ? 1 : 0;
      exp_lo = after_count(int'(v[3:0]), int'(v[3:0]));
      exp_hi = (exp_lw == 1) ? after_count(int'(v[7:4]), int'(v[7:4])) : int'(v[7:4]);
      @(posedge clk); #1;
      lo_if.Cep = 1'b0; lo_if.Cet = 1'b0;
      check($sformatf("casc_q%0d", t),     32'({hi_if.Q, lo_if.Q}), 32'((exp_hi << 4) | exp_lo));
      check($sformatf("casc_lwrap%0d", t), 32'(lo_if.WRAP), 32'(exp_lw));
      check($sformatf("casc_hwrap%0d", t), 32'(hi_if.WRAP), 32'(exp_hw));
`ifndef CYQ_DOWN_COUNTER_RELOAD_EN
      check($sformatf("casc_8bit%0d", t), 32'({hi_if.Q, lo_if.Q}), 32'((int'(v) + 255) % 256));
`endif
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
